// File: rtl/mult_booth.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_booth : sequential signed 32x32 radix-2 Booth multiplier, 64-bit HI/LO
// Revision   : 1.0
// ---------------------------------------------------------------------------
module mult_booth (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [32:0] acc;
  logic [32:0] mcand;
  logic [31:0] mplier;
  logic        q_m1;
  logic [4:0]  count;

  logic [32:0] sum;
  logic [32:0] acc_nxt;
  logic [31:0] mplier_nxt;

  // 33-bit accumulator keeps -M representable when M = -2^31.
  always_comb begin
    sum = acc;
    case ({mplier[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
  end

  assign acc_nxt    = {sum[32], sum[32:1]};
  assign mplier_nxt = {sum[0], mplier[31:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      q_m1   <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {operand_a[31], operand_a};
            mplier <= operand_b;
            acc    <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          q_m1   <= mplier[0];
          count  <= count + 5'd1;
          // Last iteration: publish the post-shift product.
          if (count == 5'd31) begin
            hi    <= acc_nxt[31:0];
            lo    <= mplier_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_booth.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_booth : scoreboard bench for mult_booth with directed vectors
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_mult_booth;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_booth dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] hold_hi = '0;
  logic [31:0] hold_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      check("done_busy_exclusive", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=done_high required=no_done (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.at);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("busy_length", busy_cnt, 32);
        hold_hi = e.hi;
        hold_lo = e.lo;
      end
      busy_cnt = 0;
    end else if (sb.size() > 0 && cyc > sb[0].at) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL done_timeout actual=no_done required=done_at_%0d (cycle %0d)", e.at, cyc);
    end
    if (busy) begin
      check("hi_hold", hi, hold_hi);
      check("lo_hold", lo, hold_lo);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    @(posedge clk);
    #1;
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    sb.push_back('{eh, el, cyc + 33});
    @(posedge clk);
    #1;
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle actual=pending_%0d required=0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    reset     = 1'b1;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    issue(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);                  wait_idle();
    issue(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);           wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);   wait_idle();
    issue(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);   wait_idle();
    issue(32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);   wait_idle();
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);   wait_idle();

    // start mid-run must be ignored
    issue(32'd3, 32'd5, 32'h0, 32'hF);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; operand_a = 32'd2; operand_b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (40) @(posedge clk);

    // reset mid-run aborts without a result
    @(posedge clk);
    #1;
    start = 1'b1; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    hold_hi = '0;
    hold_lo = '0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (40) @(posedge clk);

    // start together with reset is dropped
    #1;
    start = 1'b1; reset = 1'b1; operand_a = 32'd7; operand_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0; reset = 1'b0;
    check("start_reset_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);

    issue(32'd4, 32'd4, 32'h0, 32'h10);
    wait_idle();

    // back-to-back: start in the done cycle
    issue(32'd3, 32'd5, 32'h0, 32'hF);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (done) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL b2b_done_seen actual=no_done required=done");
    end else begin
      start = 1'b1; operand_a = 32'd9; operand_b = 32'd9;
      sb.push_back('{32'h0, 32'h51, cyc + 33});
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_idle();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
